z_result_stage: RTL and testbench

Result-capture stage directly downstream of the ALU. Latches the ALU's low result and high/carry word into the Z register pair and computes condition flags. Presents the captured result to the datapath bus as one beat (narrow ops) or two beats, ZLow then ZHigh (MUL/DIV), under a valid/ready handshake. Holds off the ALU while a result is still being drained.

---
 rtl/z_result_stage.sv | 129 ++++++++++++
 tb/tb_z_result_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/z_result_stage.sv
// Z result stage: captures the ALU result into the Z pair, computes flags and drains it as one or two bus beats.
// Optional back-to-back capture on the final beat is enabled by defining ZSTAGE_B2B_EN.
module z_result_stage #(
  parameter int           WIDTH  = 8,
  parameter logic [4:0]   OP_MUL = 5'd14,
  parameter logic [4:0]   OP_DIV = 5'd15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] alu_lo,
  input  logic [WIDTH-1:0] alu_hi,
  input  logic [4:0]       op_sel,
  input  logic             alu_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_valid,
  input  logic             bus_ready,
  output logic             bus_is_hi,
  output logic [WIDTH-1:0] z_lo,
  output logic [WIDTH-1:0] z_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic [7:0]       res_count,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND_LO = 2'd1,
    S_SEND_HI = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_wide;
  logic [WIDTH-1:0] r_z_lo;
  logic [WIDTH-1:0] r_z_hi;
  logic             r_flag_z;
  logic             r_flag_n;
  logic             r_flag_c;
  logic [7:0]       r_count;
  logic [WIDTH-1:0] r_bus_out;
  logic             r_bus_valid;
  logic             r_bus_is_hi;

  logic w_in_wide;
  logic w_flag_z;
  logic w_flag_n;
  logic w_flag_c;
  logic w_accept;
  logic w_final;
  logic w_lo_to_hi;
  logic w_in_ready;
  logic w_capture;

  // Handshakes: a transfer happens on any rising edge where valid && ready.
  // The producer must hold valid and data stable until that edge; the
  // consumer may raise or drop ready freely. Both sides here obey this.
  assign w_in_wide = (op_sel == OP_MUL) || (op_sel == OP_DIV);
  assign w_flag_z  = w_in_wide ? ({alu_hi, alu_lo} == '0) : (alu_lo == '0);
  assign w_flag_n  = w_in_wide ? alu_hi[WIDTH-1] : alu_lo[WIDTH-1];
  assign w_flag_c  = ((op_sel == 5'd0) || (op_sel == 5'd1)) ? alu_hi[0] : 1'b0;

  assign w_accept   = r_bus_valid && bus_ready;
  assign w_final    = w_accept && ((r_state == S_SEND_HI) || ((r_state == S_SEND_LO) && !r_wide));
  assign w_lo_to_hi = w_accept && (r_state == S_SEND_LO) && r_wide;

`ifdef ZSTAGE_B2B_EN
  // The slot frees up on the very edge the last beat leaves.
  assign w_in_ready = (r_state == S_IDLE) || w_final;
`else
  assign w_in_ready = (r_state == S_IDLE);
`endif

  assign w_capture = alu_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= S_IDLE;
      r_wide      <= 1'b0;
      r_z_lo      <= '0;
      r_z_hi      <= '0;
      r_flag_z    <= 1'b0;
      r_flag_n    <= 1'b0;
      r_flag_c    <= 1'b0;
      r_count     <= 8'd0;
      r_bus_out   <= '0;
      r_bus_valid <= 1'b0;
      r_bus_is_hi <= 1'b0;
    end else begin
      if (w_final) begin
        r_state     <= S_IDLE;
        r_bus_valid <= 1'b0;
        r_bus_is_hi <= 1'b0;
        r_count     <= r_count + 8'd1;
      end else if (w_lo_to_hi) begin
        r_state     <= S_SEND_HI;
        r_bus_out   <= r_z_hi;
        r_bus_is_hi <= 1'b1;
      end
      // A capture overrides the completion path so a new result can follow immediately.
      if (w_capture) begin
        r_state     <= S_SEND_LO;
        r_wide      <= w_in_wide;
        r_z_lo      <= alu_lo;
        r_z_hi      <= alu_hi;
        r_flag_z    <= w_flag_z;
        r_flag_n    <= w_flag_n;
        r_flag_c    <= w_flag_c;
        r_bus_out   <= alu_lo;
        r_bus_valid <= 1'b1;
        r_bus_is_hi <= 1'b0;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign bus_out     = r_bus_out;
  assign bus_valid   = r_bus_valid;
  assign bus_is_hi   = r_bus_is_hi;
  assign z_lo        = r_z_lo;
  assign z_hi        = r_z_hi;
  assign flag_z      = r_flag_z;
  assign flag_n      = r_flag_n;
  assign flag_c      = r_flag_c;
  assign res_count   = r_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_z_result_stage.sv
// Bench for z_result_stage: directed steps plus random results, with a beat-level reference model and scoreboard.
module tb_z_result_stage;

  localparam int W = 8;

  logic         clk;
  logic         clr;
  logic [W-1:0] alu_lo;
  logic [W-1:0] alu_hi;
  logic [4:0]   op_sel;
  logic         alu_valid;
  logic         in_ready;
  logic [W-1:0] bus_out;
  logic         bus_valid;
  logic         bus_ready;
  logic         bus_is_hi;
  logic [W-1:0] z_lo;
  logic [W-1:0] z_hi;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic [7:0]   res_count;
  logic [1:0]   dbg_state;

  logic         br_force;
  logic         br_rand;
  logic         rand_mode;
  assign bus_ready = rand_mode ? br_rand : br_force;

  z_result_stage #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .alu_lo(alu_lo), .alu_hi(alu_hi), .op_sel(op_sel),
    .alu_valid(alu_valid), .in_ready(in_ready), .bus_out(bus_out),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_is_hi(bus_is_hi),
    .z_lo(z_lo), .z_hi(z_hi), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .res_count(res_count), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Entry: {last_beat_of_result, is_hi, data}
  logic [W+1:0] exp_q[$];
  logic [7:0]   model_count = 8'd0;
  logic         prev_stall  = 1'b0;
  logic [W:0]   prev_beat   = '0;

  always @(negedge clk) begin
    if (clr) begin
      exp_q.delete();
      model_count = 8'd0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, bus_valid}, 32'd1);
        chk("hold_beat", {23'd0, bus_is_hi, bus_out}, {23'd0, prev_beat});
      end
      if (bus_valid && bus_ready) begin
        chk("beat_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          logic [W+1:0] e;
          e = exp_q.pop_front();
          chk("beat_data", {24'd0, bus_out}, {24'd0, e[W-1:0]});
          chk("beat_is_hi", {31'd0, bus_is_hi}, {31'd0, e[W]});
          if (e[W+1]) model_count = model_count + 8'd1;
        end
      end
      prev_stall = bus_valid && !bus_ready;
      prev_beat  = {bus_is_hi, bus_out};
    end
  end

  always @(posedge clk) begin
    #1;
    br_rand = 1'($urandom_range(0, 1));
  end

  function automatic logic is_wide(input logic [4:0] op);
    return (op == 5'd14) || (op == 5'd15);
  endfunction

  // Expected flags from the arithmetic meaning of the result.
  function automatic logic [2:0] model_flags(input logic [W-1:0] lo, input logic [W-1:0] hi,
                                             input logic [4:0] op);
    int unsigned value;
    logic fz, fn, fc;
    value = is_wide(op) ? (int'(hi) * 256 + int'(lo)) : int'(lo);
    fz = (value == 0);
    fn = is_wide(op) ? (value >= 32768) : (value >= 128);
    fc = (op <= 5'd1) ? hi[0] : 1'b0;
    return {fz, fn, fc};
  endfunction

  task automatic push_result(input logic [W-1:0] lo, input logic [W-1:0] hi, input logic [4:0] op);
    exp_q.push_back({!is_wide(op), 1'b0, lo});
    if (is_wide(op)) exp_q.push_back({1'b1, 1'b1, hi});
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
  endtask

  // Presents one result; returns at the negedge right after the capture edge.
  task automatic send(input logic [W-1:0] lo, input logic [W-1:0] hi, input logic [4:0] op);
    int n;
    logic [2:0] f;
    @(posedge clk); #1;
    alu_lo = lo; alu_hi = hi; op_sel = op; alu_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    push_result(lo, hi, op);
    @(posedge clk); #1;
    alu_valid = 1'b0;
    @(negedge clk);
    f = model_flags(lo, hi, op);
    chk("latency_valid", {31'd0, bus_valid}, 32'd1);
    chk("z_lo", {24'd0, z_lo}, {24'd0, lo});
    chk("z_hi", {24'd0, z_hi}, {24'd0, hi});
    chk("flags_znc", {29'd0, flag_z, flag_n, flag_c}, {29'd0, f});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
    chk("res_count", {24'd0, res_count}, {24'd0, model_count});
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int beats;
    int exp_beats;
    logic cap;
    logic [W-1:0] lo, hi;
    logic [4:0] op;

    clr = 1'b1; alu_lo = '0; alu_hi = '0; op_sel = '0; alu_valid = 1'b0;
    br_force = 1'b1; rand_mode = 1'b0;
    do_reset();

    // reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_bus_out", {24'd0, bus_out}, 32'd0);
    chk("rst_bus_is_hi", {31'd0, bus_is_hi}, 32'd0);
    chk("rst_z", {16'd0, z_hi, z_lo}, 32'd0);
    chk("rst_flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
    chk("rst_count", {24'd0, res_count}, 32'd0);

    // ADD narrow result
    send(8'h07, 8'h00, 5'd0);
    chk("add_beat", {23'd0, bus_is_hi, bus_out}, {23'd0, 1'b0, 8'h07});
    wait_drain();
    chk("add_count", {24'd0, res_count}, 32'd1);

    // MUL wide result: lo then hi on consecutive cycles
    send(8'h2C, 8'h01, 5'd14);
    chk("mul_lo", {23'd0, bus_is_hi, bus_out}, {23'd0, 1'b0, 8'h2C});
    @(negedge clk);
    chk("mul_hi", {22'd0, bus_valid, bus_is_hi, bus_out}, {22'd0, 1'b1, 1'b1, 8'h01});
    wait_drain();

    // Backpressure on a SUB, with an ignored capture attempt during the stall
    br_force = 1'b0;
    send(8'h00, 8'h01, 5'd1);
    alu_lo = 8'hAA; alu_hi = 8'h55; op_sel = 5'd14;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      alu_valid = (i == 1);
      @(negedge clk);
      chk("stall_state", {22'd0, bus_valid, in_ready, bus_out}, {22'd0, 1'b1, 1'b0, 8'h00});
    end
    chk("stall_z_kept", {16'd0, z_hi, z_lo}, {16'd0, 8'h01, 8'h00});
    chk("stall_flags", {29'd0, flag_z, flag_c}, {29'd0, 1'b1, 1'b1});
    @(posedge clk); #1;
    br_force = 1'b1;
    wait_drain();

    // Reset while the high beat of a MUL is pending
    send(8'h34, 8'h12, 5'd14);
    @(posedge clk); #1;
    br_force = 1'b0;
    @(negedge clk);
    chk("pre_clr_hi", {30'd0, bus_valid, bus_is_hi}, {30'd0, 1'b1, 1'b1});
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    br_force = 1'b1;
    @(negedge clk);
    chk("clr_bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("clr_z", {16'd0, z_hi, z_lo}, 32'd0);
    chk("clr_count", {24'd0, res_count}, 32'd0);
    chk("clr_in_ready", {31'd0, in_ready}, 32'd1);

    // Random results with random consumer backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 5'(14 + $urandom_range(0, 1)) : 5'($urandom_range(0, 17));
      lo = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      hi = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      send(lo, hi, op);
    end
    wait_drain();
    rand_mode = 1'b0;

    // Counter wrap after 256 narrow results
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send(8'($urandom), 8'($urandom), 5'($urandom_range(0, 13)));
    end
    wait_drain();
    chk("wrap_count", {24'd0, res_count}, 32'd0);

    // Throughput with alu_valid held and alternating 05 / 06
    alu_lo = 8'h05; alu_hi = 8'h00; op_sel = 5'd0;
    @(posedge clk); #1;
    alu_valid = 1'b1;
    beats = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cap = in_ready;
      if (cap) push_result(alu_lo, alu_hi, op_sel);
      if (i >= 2 && bus_valid && bus_ready) beats++;
      @(posedge clk); #1;
      if (cap) alu_lo = (alu_lo == 8'h05) ? 8'h06 : 8'h05;
    end
    alu_valid = 1'b0;
`ifdef ZSTAGE_B2B_EN
    exp_beats = 10;
`else
    exp_beats = 5;
`endif
    chk("stream_beats", beats, exp_beats);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
